// File: rtl/pulse_train_pkg.sv
// pulse_train_pkg: shared types and helpers for the pulse train generator.
// pulse_cfg_t is the default-width (8-bit) view of one channel's configuration.
package pulse_train_pkg;

  localparam int PULSE_N = 8;

  typedef enum logic {S_IDLE, S_RUN} pulse_state_t;

  typedef struct packed {
    logic [PULSE_N-1:0] ticks;
    logic [PULSE_N-1:0] count;
    logic [PULSE_N-1:0] width;
  } pulse_cfg_t;

  // A programmed period of zero behaves like a period of one clock.
  function automatic int unsigned ticks_eff(input int unsigned ticks);
    return (ticks == 32'd0) ? 32'd1 : ticks;
  endfunction

endpackage

// File: rtl/pulse_train_channel.sv
// pulse_train_channel: one channel of the pulse train generator.
// Holds the shadow config, the config used by the running train, the period
// and pulse counters and the IDLE/RUN state machine.
// Optional feature macro: PULSE_DUTY_EN (programmable high time).
module pulse_train_channel
  import pulse_train_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ena,
  input  logic         i_wr,
  input  logic [N-1:0] i_ticks,
  input  logic [N-1:0] i_count,
`ifdef PULSE_DUTY_EN
  input  logic [N-1:0] i_width,
`endif
  input  logic         i_start,
  input  logic         i_stop,
  output logic         o_out,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [N-1:0] L_ONE = N'(1);

  pulse_state_t r_state, w_stateNext;
  logic [N-1:0] r_cnt, w_cntNext;
  logic [N-1:0] r_pulses, w_pulsesNext;
  logic         r_done, w_doneNext;
  logic         w_adopt;

  logic [N-1:0] r_shTicks, r_shCount, r_acTicks, r_acCount;
  logic [N-1:0] w_nxTicks, w_nxCount;
  logic [N-1:0] w_ticksEff;
  logic [N:0]   w_pulsesInc;
  logic         w_run, w_wrap, w_burstEnd;

  // A write in the same cycle as a start or wrap is seen by the run.
  assign w_nxTicks   = i_wr ? i_ticks : r_shTicks;
  assign w_nxCount   = i_wr ? i_count : r_shCount;

  assign w_ticksEff  = N'(ticks_eff(32'(r_acTicks)));
  assign w_run       = (r_state == S_RUN);
  assign w_wrap      = w_run & i_ena & (r_cnt >= (w_ticksEff - L_ONE));
  assign w_pulsesInc = {1'b0, r_pulses} + (N+1)'(1);
  assign w_burstEnd  = (r_acCount != '0) && (w_pulsesInc >= {1'b0, r_acCount});

  // Next-state logic: stop beats start, start beats counting.
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_pulsesNext = r_pulses;
    w_doneNext   = 1'b0;
    w_adopt      = 1'b0;
    if (i_stop) begin
      w_stateNext  = S_IDLE;
      w_cntNext    = '0;
      w_pulsesNext = '0;
    end else if (i_start) begin
      w_stateNext  = S_RUN;
      w_cntNext    = '0;
      w_pulsesNext = '0;
      w_adopt      = 1'b1;
    end else if (w_wrap) begin
      w_cntNext = '0;
      w_adopt   = 1'b1;
      if (w_burstEnd) begin
        w_stateNext  = S_IDLE;
        w_pulsesNext = '0;
        w_doneNext   = 1'b1;
      end else begin
        w_pulsesNext = w_pulsesInc[N-1:0];
      end
    end else if (w_run && i_ena) begin
      w_cntNext = r_cnt + L_ONE;
    end
  end

  // State, counters and the done strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pulses <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_pulses <= w_pulsesNext;
      r_done   <= w_doneNext;
    end
  end

  // Shadow config takes every write; the active copy changes only on start or wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shTicks <= L_ONE;
      r_shCount <= '0;
      r_acTicks <= L_ONE;
      r_acCount <= '0;
    end else begin
      r_shTicks <= w_nxTicks;
      r_shCount <= w_nxCount;
      if (w_adopt) begin
        r_acTicks <= w_nxTicks;
        r_acCount <= w_nxCount;
      end
    end
  end

`ifdef PULSE_DUTY_EN
  logic [N-1:0] r_shWidth, r_acWidth, w_nxWidth, w_widthEff;

  assign w_nxWidth = i_wr ? i_width : r_shWidth;

  // Width tracks the other config fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shWidth <= L_ONE;
      r_acWidth <= L_ONE;
    end else begin
      r_shWidth <= w_nxWidth;
      if (w_adopt) r_acWidth <= w_nxWidth;
    end
  end

  // Clamp the high time into 1..period so the high phase ends with the period.
  always_comb begin
    w_widthEff = r_acWidth;
    if (r_acWidth == '0) w_widthEff = L_ONE;
    else if (r_acWidth > w_ticksEff) w_widthEff = w_ticksEff;
  end

  assign o_out = w_run & i_ena & (r_cnt >= (w_ticksEff - w_widthEff));
`else
  assign o_out = w_wrap;
`endif

  assign o_busy = w_run;
  assign o_done = r_done;

endmodule

// File: rtl/pulse_train_generator.sv
// pulse_train_generator: CHANNELS independent periodic/burst pulse trains.
// Decodes the config write port into per-channel write enables.
// Optional feature macro: PULSE_DUTY_EN (cfg_width sets the high time).
module pulse_train_generator
  import pulse_train_pkg::*;
#(
  parameter int N        = 8,
  parameter int CHANNELS = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [N-1:0]        cfg_ticks,
  input  logic [N-1:0]        cfg_count,
  input  logic [N-1:0]        cfg_width,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  logic [CHANNELS-1:0] w_wrEn;

`ifndef PULSE_DUTY_EN
  logic [N-1:0] w_unusedWidth;
  assign w_unusedWidth = cfg_width;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    // Out-of-range channel indices match no channel, so such writes are dropped.
    assign w_wrEn[g] = cfg_wr && (32'(cfg_ch) == 32'(g));

    pulse_train_channel #(.N(N)) u_ch (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_ena   (ena),
      .i_wr    (w_wrEn[g]),
      .i_ticks (cfg_ticks),
      .i_count (cfg_count),
`ifdef PULSE_DUTY_EN
      .i_width (cfg_width),
`endif
      .i_start (start[g]),
      .i_stop  (stop[g]),
      .o_out   (out[g]),
      .o_busy  (busy[g]),
      .o_done  (done[g])
    );
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator: directed bench for pulse_train_generator with three
// channels (so cfg_ch=3 is an out-of-range index). Duty-cycle sequences are
// built only when PULSE_DUTY_EN is defined.
module tb_pulse_train_generator;
  import pulse_train_pkg::*;

  localparam int N    = 8;
  localparam int CH   = 3;
  localparam int CH_W = 2;
  localparam int NV   = 17;

  typedef struct {
    logic          ena;
    logic          wr;
    logic [CH_W-1:0] ch;
    pulse_cfg_t    cfg;
    logic [CH-1:0] st;
    logic [CH-1:0] sp;
    logic [CH-1:0] expOut;
    logic [CH-1:0] expBusy;
    logic [CH-1:0] expDone;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ena = 1'b0;
  logic            cfg_wr = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [N-1:0]    cfg_ticks = '0;
  logic [N-1:0]    cfg_count = '0;
  logic [N-1:0]    cfg_width = '0;
  logic [CH-1:0]   start = '0;
  logic [CH-1:0]   stop = '0;
  logic [CH-1:0]   out, busy, done;

  int total = 0;
  int bad   = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  pulse_train_generator #(.N(N), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_ticks (cfg_ticks),
    .cfg_count (cfg_count),
    .cfg_width (cfg_width),
    .start     (start),
    .stop      (stop),
    .out       (out),
    .busy      (busy),
    .done      (done)
  );

  function automatic pulse_cfg_t mkCfg(input int t, input int c, input int w);
    pulse_cfg_t r;
    r.ticks = 8'(t);
    r.count = 8'(c);
    r.width = 8'(w);
    return r;
  endfunction

  function automatic vec_t mkVec(input logic e, input logic wr, input int ch, input pulse_cfg_t c,
                                 input logic [CH-1:0] st, input logic [CH-1:0] sp,
                                 input logic [CH-1:0] eo, input logic [CH-1:0] eb, input logic [CH-1:0] ed);
    vec_t v;
    v.ena = e; v.wr = wr; v.ch = CH_W'(ch); v.cfg = c;
    v.st = st; v.sp = sp; v.expOut = eo; v.expBusy = eb; v.expDone = ed;
    return v;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic applyStimulus(input logic e, input logic wr, input int ch, input pulse_cfg_t c,
                               input logic [CH-1:0] st, input logic [CH-1:0] sp);
    @(negedge clk);
    ena       = e;
    cfg_wr    = wr;
    cfg_ch    = CH_W'(ch);
    cfg_ticks = c.ticks;
    cfg_count = c.count;
    cfg_width = c.width;
    start     = st;
    stop      = sp;
    #2;
  endtask

  task automatic run(input logic e, input logic [CH-1:0] st, input logic [CH-1:0] sp);
    applyStimulus(e, 1'b0, 0, mkCfg(0, 0, 0), st, sp);
  endtask

  task automatic writeCfg(input int ch, input pulse_cfg_t c);
    applyStimulus(1'b1, 1'b1, ch, c, '0, '0);
  endtask

  task automatic checkOutput(input string name, input logic [CH-1:0] actual, input logic [CH-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string name, input logic [CH-1:0] eo, input logic [CH-1:0] eb, input logic [CH-1:0] ed);
    checkOutput({name, ".out"}, out, eo);
    checkOutput({name, ".busy"}, busy, eb);
    checkOutput({name, ".done"}, done, ed);
  endtask

  initial begin
    pulse_cfg_t z;
    int widths[3];
    z = mkCfg(0, 0, 0);
    widths = '{2, 0, 9};

    // ch1 burst ticks=3 count=2 and ch0 continuous ticks=4, started together.
    vecs[0]  = mkVec(1'b1, 1'b1, 1, mkCfg(3, 2, 1), 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    vecs[1]  = mkVec(1'b1, 1'b1, 0, mkCfg(4, 0, 1), 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    vecs[2]  = mkVec(1'b1, 1'b0, 0, z, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000);
    vecs[3]  = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b000, 3'b011, 3'b000);
    vecs[4]  = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b000, 3'b011, 3'b000);
    vecs[5]  = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b010, 3'b011, 3'b000);
    vecs[6]  = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b001, 3'b011, 3'b000);
    vecs[7]  = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b000, 3'b011, 3'b000);
    vecs[8]  = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b010, 3'b011, 3'b000);
    vecs[9]  = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010);
    vecs[10] = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000);
    vecs[11] = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vecs[12] = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vecs[13] = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000);
    vecs[14] = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000);
    vecs[15] = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000);
    vecs[16] = mkVec(1'b1, 1'b0, 0, z, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    #1 rst = 1'b1;
    #1 checkAll("reset", 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].ena, vecs[i].wr, int'(vecs[i].ch), vecs[i].cfg, vecs[i].st, vecs[i].sp);
      checkAll($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expBusy, vecs[i].expDone);
    end

    // Asynchronous reset between edges while ch0 is pulsing.
    writeCfg(0, mkCfg(4, 0, 1));
    run(1'b1, 3'b001, 3'b000);
    for (int k = 1; k <= 4; k++) begin
      run(1'b1, 3'b000, 3'b000);
      checkOutput($sformatf("preRst.out k%0d", k), out, (k == 4) ? 3'b001 : 3'b000);
    end
    #1 rst = 1'b1;
    #1 checkAll("asyncRst", 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      run(1'b1, 3'b000, 3'b000);
      checkAll($sformatf("postRst k%0d", k), 3'b000, 3'b000, 3'b000);
    end

    // ticks=1 (reset default on ch0) and ticks=0 (ch2) pulse every cycle.
    writeCfg(2, mkCfg(0, 0, 1));
    run(1'b1, 3'b101, 3'b000);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, k == 4, 2, mkCfg(1, 0, 1), 3'b000, 3'b000);
      checkOutput($sformatf("everyCycle.out k%0d", k), out, 3'b101);
    end
    run(1'b1, 3'b000, 3'b101);
    run(1'b1, 3'b000, 3'b000);
    checkOutput("everyCycle.stopped", busy, 3'b000);

    // Enable low for 5 cycles delays the pulse by 5 cycles.
    writeCfg(0, mkCfg(4, 0, 1));
    run(1'b1, 3'b001, 3'b000);
    for (int k = 1; k <= 9; k++) begin
      run(!(k >= 3 && k <= 7), 3'b000, 3'b000);
      checkOutput($sformatf("enaHold.out k%0d", k), out, (k == 9) ? 3'b001 : 3'b000);
      checkOutput($sformatf("enaHold.busy k%0d", k), busy, 3'b001);
    end
    run(1'b1, 3'b000, 3'b001);
    run(1'b1, 3'b000, 3'b000);
    checkOutput("enaHold.stopped", busy, 3'b000);

    // Start and stop together: stop wins, from IDLE and from RUN.
    run(1'b1, 3'b001, 3'b001);
    run(1'b1, 3'b000, 3'b000);
    checkOutput("startStop.idle", busy, 3'b000);
    run(1'b1, 3'b001, 3'b000);
    run(1'b1, 3'b001, 3'b001);
    checkOutput("startStop.running", busy, 3'b001);
    run(1'b1, 3'b000, 3'b000);
    checkOutput("startStop.run", busy, 3'b000);

    // Period 4 -> 2 mid-run, an out-of-range write, then a restart.
    writeCfg(0, mkCfg(4, 0, 1));
    run(1'b1, 3'b001, 3'b000);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, (k == 1) || (k == 5), (k == 1) ? 0 : 3,
                    (k == 1) ? mkCfg(2, 0, 1) : mkCfg(1, 0, 1),
                    (k == 9) ? 3'b001 : 3'b000, 3'b000);
      checkOutput($sformatf("cfgLate.out k%0d", k), out,
                  (k == 4 || k == 6 || k == 8 || k == 11) ? 3'b001 : 3'b000);
    end
    run(1'b1, 3'b000, 3'b001);
    run(1'b1, 3'b000, 3'b000);
    checkOutput("cfgLate.stopped", busy, 3'b000);

    // Burst restart suppresses done; stop on the final pulse suppresses done.
    writeCfg(1, mkCfg(3, 2, 1));
    run(1'b1, 3'b010, 3'b000);
    for (int k = 1; k <= 13; k++) begin
      run(1'b1, (k == 6) ? 3'b010 : 3'b000, (k == 12) ? 3'b010 : 3'b000);
      checkAll($sformatf("burstRestart k%0d", k),
               (k == 3 || k == 6 || k == 9 || k == 12) ? 3'b010 : 3'b000,
               (k <= 12) ? 3'b010 : 3'b000, 3'b000);
    end

    // ticks=255: two pulses 255 cycles apart, then done.
    writeCfg(2, mkCfg(255, 2, 1));
    run(1'b1, 3'b100, 3'b000);
    for (int k = 1; k <= 510; k++) begin
      run(1'b1, 3'b000, 3'b000);
      checkOutput($sformatf("t255.out k%0d", k), out, (k == 255 || k == 510) ? 3'b100 : 3'b000);
    end
    run(1'b1, 3'b000, 3'b000);
    checkAll("t255.end", 3'b000, 3'b000, 3'b100);
    run(1'b1, 3'b000, 3'b000);
    checkOutput("t255.doneOnce", done, 3'b000);

`ifdef PULSE_DUTY_EN
    // Duty: ticks=5 with widths 2, 0 and 9.
    for (int wi = 0; wi < 3; wi++) begin
      int weff;
      weff = (widths[wi] < 1) ? 1 : ((widths[wi] > 5) ? 5 : widths[wi]);
      writeCfg(0, mkCfg(5, 0, widths[wi]));
      run(1'b1, 3'b001, 3'b000);
      for (int k = 1; k <= 10; k++) begin
        run(1'b1, 3'b000, 3'b000);
        checkOutput($sformatf("duty w%0d k%0d", widths[wi], k), out,
                    (((k - 1) % 5) >= (5 - weff)) ? 3'b001 : 3'b000);
      end
      run(1'b1, 3'b000, 3'b001);
      run(1'b1, 3'b000, 3'b000);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
- Multi-channel, parametrised successor to the single-counter periodic tick generator.
- Each channel emits a train of pulses at a programmable period and stops after a programmable burst count (0 = continuous).
- Channels have independent start/stop, with done/busy status.
- Used for display refresh strobes, debouncer sampling ticks and LED blink timing.

Parameters:
- N, 8, width of period, burst-count and width fields.
- CHANNELS, 4, number of independent channels; at least 1.
- CH_W, $clog2(CHANNELS) (min 1), derived channel-index width; not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ena  input  1  global enable; low freezes all counters and forces out low
- cfg_wr  input  1  write config for channel cfg_ch this cycle
- cfg_ch  input  CH_W  target channel of cfg_wr
- cfg_ticks  input  N  period in clocks
- cfg_count  input  N  pulses per burst; 0 = continuous
- cfg_width  input  N  high time in clocks; used only with PULSE_DUTY_EN
- start  input  CHANNELS  per-channel start/restart request, level sampled each edge
- stop  input  CHANNELS  per-channel abort request
- out  output  CHANNELS  pulse outputs
- busy  output  CHANNELS  channel in RUN
- done  output  CHANNELS  one-cycle strobe when a finite burst completes

Behaviour:
- Reset (async, any time): all channels to IDLE; counters 0; pulse counters 0; shadow cfg ticks=1, count=0, width=1; out=0, busy=0, done=0.
- Per-channel state machine, two states:
  - IDLE: on start[i]=1, go to RUN; period counter and pulse counter cleared.
  - RUN: on stop[i]=1, go to IDLE with no done. On the last pulse of a finite burst, go to IDLE at the end of that pulse cycle.
- Effective period: ticks_eff = (cfg_ticks==0) ? 1 : cfg_ticks.
- Counter:
  - In RUN with ena=1, counter increments.
  - On reaching ticks_eff-1, counter wraps to 0 on the next edge.
  - ena=0 holds the counter and the pulse counter.
- Pulse output: out[i] = RUN & ena & (counter == ticks_eff-1). This is combinational from registered state.
- Latency:
  - The start edge enters RUN with counter 0.
  - The first pulse is in the ticks_eff-th RUN cycle; later pulses follow every ticks_eff enabled cycles.
  - With ticks_eff=1, out is high every enabled RUN cycle.
- Burst accounting:
  - Pulse counter increments on each out cycle.
  - When count != 0 and the pulse counter reaches count on a pulse cycle, done[i]=1 in the following cycle and busy[i]=0 in that same cycle.
- busy[i] = (state==RUN), registered.
- Config updates:
  - cfg_wr loads the shadow registers for cfg_ch.
  - A channel in IDLE uses new values immediately.
  - A channel in RUN adopts them at the next wrap, i.e. on the edge after a pulse cycle, so the period is never truncated.
  - cfg_ch >= CHANNELS: the write is ignored.
- Simultaneous events:
  - start and stop on the same channel: stop wins.
  - start while RUN: restart, clearing both counters; done is not asserted.
  - cfg_wr and start on the same channel in the same cycle: the run uses the new cfg values.
  - stop on the same edge as burst completion: IDLE, done suppressed.
- Width rule: all counters are N bits. Compare with >= so that a ticks reduction adopted late cannot overrun; counter never exceeds 2^N-1.

Optional Feature:
- PULSE_DUTY_EN defined:
  - out[i] = RUN & ena & (counter >= ticks_eff - w_eff), where w_eff = clamp(cfg_width, 1, ticks_eff).
  - The high time ends aligned to the period end.
  - Burst pulses are counted on the last high cycle.
  - cfg_width is shadowed like the other fields.
- PULSE_DUTY_EN not defined:
  - cfg_width is ignored and not stored.
  - out is exactly one cycle per period.

Decomposition:
- Package pulse_train_pkg holds:
  - typedef enum logic {S_IDLE, S_RUN} pulse_state_t;
  - a cfg struct {ticks, count, width}, parametrised by N via a localparam default of 8;
  - a function computing ticks_eff.
- Sub-module pulse_train_channel implements one channel: shadow config, counters and the state machine.
- The top level instantiates CHANNELS copies with a generate loop and decodes cfg_wr/cfg_ch into per-channel write enables.

Test Plan:
- Reset mid-run: ch0 ticks=4 running, assert rst asynchronously between edges -> out, busy, done all 0 immediately; after release, ch0 stays IDLE until start.
- Periodic: ch0 ticks=4, count=0, start pulse -> out[0] high on RUN cycles 4, 8, 12; busy stays 1; done never asserts.
- Burst: ch1 ticks=3, count=2 -> pulses on RUN cycles 3 and 6; done[1] high on cycle 7 for one cycle; busy[1]=0 from cycle 7.
- Edge values: ticks=0 and ticks=1 -> out every enabled RUN cycle. ticks=255 -> first pulse on RUN cycle 255, counter wraps to 0 and does not overflow.
- Enable and conflicts:
  - ena low for 5 cycles mid-period -> pulse delayed by exactly 5 cycles.
  - start and stop together -> IDLE.
  - cfg_wr ticks 4->2 during RUN -> current period completes at 4, next period is 2.
- Duty (PULSE_DUTY_EN): ticks=5, width=2 -> out high on counter 3 and 4 each period. width=0 -> 1 cycle high. width=9 -> out constantly high.
